// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: register-file write port arbiter for the WB stage and an aux FIFO (optional RF_ZERO_REG_EN drops writes to register 0)
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int AW       = 4,
  parameter int DW       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DW-1:0]     wb_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [AW-1:0]     aux_rd,
  input  logic [DW-1:0]     aux_data,
  output logic              wb_stall,
  output logic [2**AW-1:0]  pend_mask,
  output logic              rf_we,
  output logic [AW-1:0]     rf_wa,
  output logic [DW-1:0]     rf_wd
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] q_rd [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [3:0] wait_cnt, wait_nxt;
  logic empty, push, pop, wb_grant, zero_ok;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_wd;
  assign empty     = count == '0;
  assign aux_ready = count != (PW+1)'(DEPTH);
  assign push      = aux_valid & aux_ready;
  // a registered stall hands the port to the queue head; otherwise WB wins and the queue drains in idle slots
  assign pop       = !empty & (wb_stall | !wb_we);
  assign wb_grant  = !pop & wb_we;
  assign sel_rd    = pop ? q_rd[rd_ptr] : wb_rd;
  assign sel_wd    = pop ? q_data[rd_ptr] : wb_data;
`ifdef RF_ZERO_REG_EN
  assign zero_ok   = sel_rd != '0;
`else
  assign zero_ok   = 1'b1;
`endif
  // starvation counter: counts consecutive denied cycles of a waiting head
  assign wait_nxt  = (empty | pop) ? 4'd0 : (wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1);
  // queue storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= aux_rd;
      q_data[wr_ptr] <= aux_data;
    end
  end
  // queue bookkeeping, starvation stall and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      wb_stall <= 1'b0;
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      wait_cnt <= wait_nxt;
      wb_stall <= wait_nxt == 4'(MAX_WAIT);
      rf_we    <= (pop | wb_grant) & zero_ok;
      if (pop | wb_grant) begin
        rf_wa <= sel_rd;
        rf_wd <= sel_wd;
      end
    end
  end
  // destinations still waiting in the queue, for the hazard unit
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count) pend_mask[q_rd[rd_ptr + PW'(i)]] = 1'b1;
`ifdef RF_ZERO_REG_EN
    pend_mask[0] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed table, corner sequences and randomized model check of rf_write_arbiter
module tb_rf_write_arbiter;
  localparam int DEPTH = 2, MAX_WAIT = 4, AW = 4, DW = 32;
`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic wb_we = 0, aux_valid = 0, aux_ready, wb_stall, rf_we;
  logic [AW-1:0] wb_rd = 0, aux_rd = 0, rf_wa;
  logic [DW-1:0] wb_data = 0, aux_data = 0, rf_wd;
  logic [2**AW-1:0] pend_mask;
  int passed = 0, total = 0;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
    .wb_stall(wb_stall), .pend_mask(pend_mask), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd));

  always #5 clk = ~clk;

  typedef struct {
    logic wb_we; logic [AW-1:0] wb_rd; logic [DW-1:0] wb_data;
    logic av; logic [AW-1:0] ard; logic [DW-1:0] adata;
    logic e_we; logic [AW-1:0] e_wa; logic [DW-1:0] e_wd;
    logic e_stall; logic e_ready; logic [2**AW-1:0] e_mask;
  } vec_t;
  vec_t vt [17];

  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;
  ent_t mq [$];
  int m_wait;
  logic m_stall, m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [2**AW-1:0] model_mask();
    logic [2**AW-1:0] m = '0;
    foreach (mq[i]) if (!(ZR && mq[i].rd == 0)) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  // advance one clock with the current inputs, updating the queue model from the arbitration rules
  task automatic step(input string tag);
    bit pop, wbg, was_empty;
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    if (rst) begin
      mq.delete(); m_wait = 0; m_stall = 0; m_we = 0; m_wa = 0; m_wd = 0;
    end else begin
      was_empty = mq.size() == 0;
      pop = !was_empty && (m_stall || !wb_we);
      wbg = !pop && wb_we;
      rd = pop ? mq[0].rd : wb_rd;
      d  = pop ? mq[0].data : wb_data;
      m_we = (pop || wbg) && !(ZR && rd == 0);
      if (pop || wbg) begin m_wa = rd; m_wd = d; end
      if (pop) void'(mq.pop_front());
      if (aux_valid && mq.size() + (pop ? 1 : 0) < DEPTH) mq.push_back('{aux_rd, aux_data});
      m_wait = (was_empty || pop) ? 0 : (m_wait < MAX_WAIT ? m_wait + 1 : MAX_WAIT);
      m_stall = m_wait == MAX_WAIT;
    end
    @(posedge clk); #1;
    chk({tag, "_rf_we"}, rf_we, m_we);
    chk({tag, "_stall"}, wb_stall, m_stall);
    chk({tag, "_ready"}, aux_ready, mq.size() < DEPTH);
    chk({tag, "_mask"}, pend_mask, model_mask());
    if (m_we) begin
      chk({tag, "_rf_wa"}, rf_wa, m_wa);
      chk({tag, "_rf_wd"}, rf_wd, m_wd);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] r, input logic [DW-1:0] d,
                       input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad);
    wb_we = we; wb_rd = r; wb_data = d; aux_valid = av; aux_rd = ar; aux_data = ad;
  endtask

  initial begin
    vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 1, 16'h0000};
    vt[1]  = '{0, 0, 0,            1, 3, 32'h12, 0, 0, 0,            0, 1, 16'h0008};
    vt[2]  = '{0, 0, 0,            0, 0, 0,      1, 3, 32'h12,       0, 1, 16'h0000};
    vt[3]  = '{1, 0, 32'hFF,       0, 0, 0,      !ZR, 0, 32'hFF,     0, 1, 16'h0000};
    vt[4]  = '{0, 0, 0,            0, 0, 0,      0, 0, 0,            0, 1, 16'h0000};
    vt[5]  = '{1, 10, 32'hB0A,     1, 1, 32'h111, 1, 10, 32'hB0A,    0, 1, 16'h0002};
    vt[6]  = '{1, 11, 32'hB0B,     1, 2, 32'h222, 1, 11, 32'hB0B,    0, 0, 16'h0006};
    vt[7]  = '{1, 12, 32'hB0C,     1, 4, 32'h444, 1, 12, 32'hB0C,    0, 0, 16'h0006};
    vt[8]  = '{1, 13, 32'hB0D,     0, 0, 0,      1, 13, 32'hB0D,     0, 0, 16'h0006};
    vt[9]  = '{1, 14, 32'hB0E,     0, 0, 0,      1, 14, 32'hB0E,     1, 0, 16'h0006};
    vt[10] = '{1, 15, 32'hB0F,     0, 0, 0,      1, 1, 32'h111,      0, 1, 16'h0004};
    vt[11] = '{1, 9, 32'hB09,      0, 0, 0,      1, 9, 32'hB09,      0, 1, 16'h0004};
    vt[12] = '{1, 9, 32'hB09,      0, 0, 0,      1, 9, 32'hB09,      0, 1, 16'h0004};
    vt[13] = '{1, 9, 32'hB09,      0, 0, 0,      1, 9, 32'hB09,      0, 1, 16'h0004};
    vt[14] = '{1, 9, 32'hB09,      0, 0, 0,      1, 9, 32'hB09,      1, 1, 16'h0004};
    vt[15] = '{1, 9, 32'hB09,      0, 0, 0,      1, 2, 32'h222,      0, 1, 16'h0000};
    vt[16] = '{0, 0, 0,            0, 0, 0,      0, 0, 0,            0, 1, 16'h0000};

    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wa", rf_wa, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_ready", aux_ready, 1);
    chk("rst_mask", pend_mask, 0);
    rst = 0;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].wb_we, vt[i].wb_rd, vt[i].wb_data, vt[i].av, vt[i].ard, vt[i].adata);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rf_we", i), rf_we, vt[i].e_we);
      chk($sformatf("vec%0d_stall", i), wb_stall, vt[i].e_stall);
      chk($sformatf("vec%0d_ready", i), aux_ready, vt[i].e_ready);
      chk($sformatf("vec%0d_mask", i), pend_mask, vt[i].e_mask);
      if (vt[i].e_we) begin
        chk($sformatf("vec%0d_rf_wa", i), rf_wa, vt[i].e_wa);
        chk($sformatf("vec%0d_rf_wd", i), rf_wd, vt[i].e_wd);
      end
    end

    rst = 1; drive(0, 0, 0, 0, 0, 0);
    step("sync_rst");
    rst = 0;
    drive(1, 6, 32'h66, 1, 7, 32'h77);
    step("full_a");
    drive(1, 6, 32'h66, 1, 9, 32'h99);
    step("full_b");
    chk("full_ready_low", aux_ready, 0);
    chk("full_mask", pend_mask, 16'h0280);
    rst = 1; drive(1, 6, 32'h66, 0, 0, 0);
    step("mid_rst");
    rst = 0; drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step("post_rst");
      chk("no_stale_write", rf_we && (rf_wa == 7 || rf_wa == 9), 0);
    end

    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 79) == 0;
      wb_we = (i < 1500) ? ($urandom_range(0, 7) != 0) : $urandom_range(0, 1);
      wb_rd = AW'($urandom_range(0, 15));
      wb_data = $urandom;
      aux_valid = $urandom_range(0, 1);
      aux_rd = AW'($urandom_range(0, 15));
      aux_data = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
